// File: rtl/memlcd_pkg.sv
// memlcd_pkg: shared types and constants for the memory-LCD stream receiver
package memlcd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_MODE, S_ADDR, S_DATA, S_TRAIL, S_SKIP} state_e;
  localparam int M0 = 7;
  localparam int M1 = 6;
  localparam int M2 = 5;
  localparam int WORD_W = 32;
  function automatic int widx_w(input int pixels);
    return $clog2((pixels + WORD_W - 1) / WORD_W);
  endfunction
endpackage

// File: rtl/memlcd_rx_sync.sv
// memlcd_rx_sync: two-flop synchronizers for the LCD pins plus edge detection
module memlcd_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic sclk,
  input  logic si,
  input  logic scs,
  output logic si_s,
  output logic sclk_rise,
  output logic scs_s,
  output logic scs_rise,
  output logic scs_fall
);
  logic [2:0] sclk_q, sclk_d, scs_q, scs_d;
  logic [1:0] si_q, si_d;
  always_comb begin
    sclk_d = {sclk_q[1:0], sclk};
    scs_d  = {scs_q[1:0], scs};
    si_d   = {si_q[0], si};
  end
  // scs chain resets high so a select held high through reset never looks like a fresh rise
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q <= '0;
      scs_q  <= '1;
      si_q   <= '0;
    end else begin
      sclk_q <= sclk_d;
      scs_q  <= scs_d;
      si_q   <= si_d;
    end
  end
  assign si_s      = si_q[1];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign scs_s     = scs_q[1];
  assign scs_rise  = scs_q[1] & ~scs_q[2];
  assign scs_fall  = ~scs_q[1] & scs_q[2];
endmodule

// File: rtl/memlcd_rx_capture.sv
// memlcd_rx_capture: decodes the memory-LCD serial stream into 32-bit pixel words
module memlcd_rx_capture
  import memlcd_pkg::*;
#(
  parameter int MODE_BITS    = 8,
  parameter int ADDR_BITS    = 8,
  parameter int LINE_PIXELS  = 336,
  parameter int TRAILER_BITS = 8,
  localparam int WIDX_W      = widx_w(LINE_PIXELS)
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 lcd_sclk,
  input  logic                 lcd_si,
  input  logic                 lcd_scs,
  output logic                 wr_valid,
  output logic [ADDR_BITS-1:0] wr_line,
  output logic [WIDX_W-1:0]    wr_word,
  output logic [WORD_W-1:0]    wr_data,
  output logic                 vcom,
  output logic                 clear_stb,
  output logic                 frame_done,
  output logic                 frame_err,
  output logic [15:0]          line_count
);
  localparam int CNT_W = $clog2(LINE_PIXELS);
  logic si_s, sclk_rise, scs_s, scs_rise, scs_fall;
  memlcd_rx_sync u_sync (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .sclk     (lcd_sclk),
    .si       (lcd_si),
    .scs      (lcd_scs),
    .si_s     (si_s),
    .sclk_rise(sclk_rise),
    .scs_s    (scs_s),
    .scs_rise (scs_rise),
    .scs_fall (scs_fall)
  );
  state_e                state_q, state_d, st_t;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_t;
  logic                  armed_q, armed_d;
  logic [MODE_BITS-1:0]  mode_q, mode_d, mode_sh;
  logic [ADDR_BITS-1:0]  addr_q, addr_d, addr_sh;
  logic [WORD_W-1:0]     word_q, word_d, word_sh;
  logic [WIDX_W-1:0]     widx_q, widx_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_BITS-1:0]  wr_line_q, wr_line_d;
  logic [WIDX_W-1:0]     wr_word_q, wr_word_d;
  logic [WORD_W-1:0]     wr_data_q, wr_data_d;
  logic                  vcom_q, vcom_d, clear_q, clear_d, done_q, done_d, err_q, err_d;
  logic [15:0]           lc_q, lc_d;
  logic                  fin_mode, fin_addr, last_bit, fin_word, fin_trail, start, ending;
  assign mode_sh   = {mode_q[MODE_BITS-2:0], si_s};
  assign addr_sh   = {addr_q[ADDR_BITS-2:0], si_s};
  assign word_sh   = {word_q[WORD_W-2:0], si_s};
  assign fin_mode  = sclk_rise && state_q == S_MODE  && cnt_q == CNT_W'(MODE_BITS - 1);
  assign fin_addr  = sclk_rise && state_q == S_ADDR  && cnt_q == CNT_W'(ADDR_BITS - 1);
  assign last_bit  = sclk_rise && state_q == S_DATA  && cnt_q == CNT_W'(LINE_PIXELS - 1);
  assign fin_word  = sclk_rise && state_q == S_DATA  && (cnt_q[4:0] == 5'd31 || last_bit);
  assign fin_trail = sclk_rise && state_q == S_TRAIL && cnt_q == CNT_W'(TRAILER_BITS - 1);
  assign start     = state_q == S_IDLE && armed_q && scs_rise;
  assign ending    = state_q != S_IDLE && scs_fall;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      armed_q    <= 1'b0;
      mode_q     <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      widx_q     <= '0;
      wr_valid_q <= 1'b0;
      wr_line_q  <= '0;
      wr_word_q  <= '0;
      wr_data_q  <= '0;
      vcom_q     <= 1'b0;
      clear_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      lc_q       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      widx_q     <= widx_d;
      wr_valid_q <= wr_valid_d;
      wr_line_q  <= wr_line_d;
      wr_word_q  <= wr_word_d;
      wr_data_q  <= wr_data_d;
      vcom_q     <= vcom_d;
      clear_q    <= clear_d;
      done_q     <= done_d;
      err_q      <= err_d;
      lc_q       <= lc_d;
    end
  end
  // st_t/cnt_t: state after taking this cycle's bit, before the select-fall rule
  always_comb begin
    st_t  = state_q;
    cnt_t = cnt_q;
    if (sclk_rise && state_q inside {S_MODE, S_ADDR, S_DATA, S_TRAIL}) cnt_t = cnt_q + CNT_W'(1);
    if (fin_mode) begin
      st_t  = mode_sh[M0] ? S_ADDR : S_SKIP;
      cnt_t = '0;
    end
    if (fin_addr) begin
      st_t  = S_DATA;
      cnt_t = '0;
    end
    if (last_bit) begin
      st_t  = S_TRAIL;
      cnt_t = '0;
    end
    if (fin_trail) begin
      st_t  = S_ADDR;
      cnt_t = '0;
    end
    state_d = ending ? S_IDLE : start ? S_MODE : st_t;
    cnt_d   = start ? '0 : cnt_t;
  end
  always_comb begin
    armed_d    = armed_q | ~scs_s;
    mode_d     = (sclk_rise && state_q == S_MODE) ? mode_sh : mode_q;
    addr_d     = (sclk_rise && state_q == S_ADDR) ? addr_sh : addr_q;
    word_d     = (sclk_rise && state_q == S_DATA) ? word_sh : word_q;
    widx_d     = fin_addr ? '0 : fin_word ? widx_q + WIDX_W'(1) : widx_q;
    wr_valid_d = fin_word;
    wr_line_d  = fin_addr ? addr_sh : wr_line_q;
    wr_word_d  = fin_word ? widx_q : wr_word_q;
    wr_data_d  = !fin_word ? wr_data_q : last_bit ? word_sh << (5'd31 - cnt_q[4:0]) : word_sh;
    vcom_d     = fin_mode ? mode_sh[M1] : vcom_q;
    clear_d    = fin_mode & mode_sh[M2];
    done_d     = ending && (st_t inside {S_TRAIL, S_SKIP} || (st_t == S_ADDR && cnt_t == '0));
    err_d      = ending && !done_d;
    lc_d       = start ? '0 : (fin_trail && lc_q != 16'hFFFF) ? lc_q + 16'd1 : lc_q;
  end
  assign wr_valid   = wr_valid_q;
  assign wr_line    = wr_line_q;
  assign wr_word    = wr_word_q;
  assign wr_data    = wr_data_q;
  assign vcom       = vcom_q;
  assign clear_stb  = clear_q;
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign line_count = lc_q;
endmodule
